// File: rtl/bram_loader_pkg.sv
// Shared signal-generator definitions: loader FSM encoding and default BRAM geometry.
// The BRAM sample reader imports the same package.
package bram_loader_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;
    localparam int LAST_ADDR      = DEPTH - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_PAD,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/bram_wr_port.sv
// Registered BRAM write port: a request in one cycle appears as a write the next cycle.
// Address and data hold their last written values between writes.
module bram_wr_port #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_data <= '0;
        end else begin
            bram_we <= wr_req;
            if (wr_req) begin
                bram_addr <= wr_addr;
                bram_data <= wr_data;
            end
        end
    end

endmodule

// File: rtl/bram_loader.sv
// Loads a valid/ready word stream into the waveform BRAM from address 0, then pulses arm.
// BRAM_LOADER_PAD_EN: fill addresses after a short stream with pad_value.
module bram_loader
    import bram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  reader_busy,
    input  logic [DATA_WIDTH-1:0] pad_value,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_we,
    output logic [DATA_WIDTH-1:0] bram_data_o,
    output logic                  arm,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic                  truncated
);

    localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

    loader_state_t         state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  hs;
    logic                  at_last;
    logic                  wr_req;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  load_ok;

    assign s_tready = (state == ST_LOAD) || (state == ST_DRAIN);
    assign hs       = s_tvalid && s_tready;
    assign at_last  = (cnt == LAST);
    assign busy     = (state != ST_IDLE);
    assign load_ok  = (state == ST_IDLE) && start && !reader_busy;
    // DONE lingers while the final registered write is still on the port, so arm follows it
    assign arm      = (state == ST_DONE) && !bram_we;

`ifndef BRAM_LOADER_PAD_EN
    logic unused_pad;
    assign unused_pad = ^pad_value;
`endif

    always_comb begin
        wr_req  = 1'b0;
        wr_data = s_tdata;
        if (state == ST_LOAD && hs) begin
            wr_req = 1'b1;
        end
`ifdef BRAM_LOADER_PAD_EN
        if (state == ST_PAD) begin
            wr_req  = 1'b1;
            wr_data = pad_value;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (load_ok) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (hs) begin
                    if (at_last) begin
                        state_nxt = s_tlast ? ST_DONE : ST_DRAIN;
                    end else if (s_tlast) begin
`ifdef BRAM_LOADER_PAD_EN
                        state_nxt = ST_PAD;
`else
                        state_nxt = ST_DONE;
`endif
                    end
                end
            end
            ST_DRAIN: if (hs && s_tlast) state_nxt = ST_DONE;
            ST_PAD:   if (at_last) state_nxt = ST_DONE;
            ST_DONE:  if (!bram_we) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            words_loaded <= '0;
            truncated    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_ok) begin
                cnt          <= '0;
                words_loaded <= '0;
                truncated    <= 1'b0;
            end
            if (wr_req && !at_last) begin
                cnt <= cnt + 1'b1;
            end
            if (state == ST_LOAD && hs) begin
                words_loaded <= words_loaded + 1'b1;
                if (at_last && !s_tlast) begin
                    truncated <= 1'b1;
                end
            end
        end
    end

    bram_wr_port #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wr_port (
        .clk      (clk),
        .rst      (rst),
        .wr_req   (wr_req),
        .wr_addr  (cnt),
        .wr_data  (wr_data),
        .bram_we  (bram_we),
        .bram_addr(bram_addr),
        .bram_data(bram_data_o)
    );

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader at ADDR_WIDTH=4: full, short, overlong, gapped, ignored-start and reset loads.
module tb_bram_loader;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam logic [DW-1:0] PAD = 32'h0000_DEAD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          reader_busy = 1'b0;
    logic [DW-1:0] pad_value = PAD;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic [DW-1:0] bram_data_o;
    logic          arm;
    logic          busy;
    logic [AW:0]   words_loaded;
    logic          truncated;

    bram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .reader_busy (reader_busy),
        .pad_value   (pad_value),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .bram_addr   (bram_addr),
        .bram_we     (bram_we),
        .bram_data_o (bram_data_o),
        .arm         (arm),
        .busy        (busy),
        .words_loaded(words_loaded),
        .truncated   (truncated)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];
    int arm_count = 0;
    int arm_cyc = -1;
    int last_we_cyc = -1;
    int first_we_cyc = -1;
    int first_hs_cyc = -1;
    int last_hs_cyc = -1;
    int we_bad = 0;
    bit prev_tready = 0;
    bit prev_hs = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bram_we) begin
            log_addr.push_back(bram_addr);
            log_data.push_back(bram_data_o);
            last_we_cyc = cyc;
            if (first_we_cyc < 0) first_we_cyc = cyc;
            if (prev_tready && !prev_hs) we_bad++;
        end
        if (s_tvalid && s_tready) begin
            last_hs_cyc = cyc;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
        end
        if (arm) begin
            arm_count++;
            arm_cyc = cyc;
        end
        prev_tready = s_tready;
        prev_hs     = s_tvalid && s_tready;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        arm_count    = 0;
        arm_cyc      = -1;
        last_we_cyc  = -1;
        first_we_cyc = -1;
        first_hs_cyc = -1;
        last_hs_cyc  = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int n, input logic [DW-1:0] base, input bit end_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int to = 0;
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    s_tvalid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            s_tvalid = 1'b1;
            s_tdata  = base + DW'(i);
            s_tlast  = end_last && (i == n - 1);
            while (!s_tready && to < 50) begin
                @(posedge clk); #1;
                to++;
            end
            if (to >= 50) begin
                chk("send_timeout", 1, 0);
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int to = 0;
        while (busy && to < 200) begin
            @(posedge clk); #1;
            to++;
        end
        chk({tag, "_idle"}, busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string tag, input int n, input logic [DW-1:0] base);
        int exp_n = n;
`ifdef BRAM_LOADER_PAD_EN
        if (n < 2 ** AW) exp_n = 2 ** AW;
`endif
        chk({tag, "_nwrites"}, log_addr.size(), exp_n);
        for (int i = 0; i < exp_n && i < log_addr.size(); i++) begin
            logic [DW-1:0] exp_d;
            exp_d = (i < n) ? base + DW'(i) : PAD;
            chk($sformatf("%s_addr%0d", tag, i), log_addr[i], i);
            chk($sformatf("%s_data%0d", tag, i), log_data[i], exp_d);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", s_tready, 0);
        chk("rst_we", bram_we, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_data", bram_data_o, 0);
        chk("rst_arm", arm, 0);
        chk("rst_busy", busy, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_trunc", truncated, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // exactly-full waveform
        clear_log();
        pulse_start();
        chk("t1_busy", busy, 1);
        chk("t1_tready", s_tready, 1);
        send(16, 32'h100, 1, 0);
        wait_idle("t1");
        check_log("t1", 16, 32'h100);
        chk("t1_latency", first_we_cyc, first_hs_cyc + 1);
        chk("t1_words", words_loaded, 16);
        chk("t1_trunc", truncated, 0);
        chk("t1_arms", arm_count, 1);
        chk("t1_arm_time", arm_cyc, last_we_cyc + 1);

        // short waveform: padded or left as-is depending on build
        clear_log();
        pulse_start();
        send(5, 32'h200, 1, 0);
        wait_idle("t2");
        check_log("t2", 5, 32'h200);
        chk("t2_words", words_loaded, 5);
        chk("t2_trunc", truncated, 0);
        chk("t2_arms", arm_count, 1);
        chk("t2_arm_time", arm_cyc, last_we_cyc + 1);

        // overlong waveform is truncated and the tail drained
        clear_log();
        pulse_start();
        send(20, 32'h600, 1, 0);
        wait_idle("t3");
        check_log("t3", 16, 32'h600);
        chk("t3_words", words_loaded, 16);
        chk("t3_trunc", truncated, 1);
        chk("t3_arms", arm_count, 1);
        chk("t3_arm_time", arm_cyc, last_hs_cyc + 1);

        // start while the reader is busy is dropped
        clear_log();
        reader_busy = 1'b1;
        pulse_start();
        reader_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5a_busy", busy, 0);
        chk("t5a_words", words_loaded, 16);
        chk("t5a_trunc", truncated, 1);
        chk("t5a_nwrites", log_addr.size(), 0);

        // gapped stream matches the gap-free result
        clear_log();
        we_bad = 0;
        reader_busy = 1'b1;
        pulse_start();
        reader_busy = 1'b0;
        chk("t4_busy_ignored", busy, 0);
        pulse_start();
        reader_busy = 1'b1;
        send(16, 32'h100, 1, 1);
        reader_busy = 1'b0;
        wait_idle("t4");
        check_log("t4", 16, 32'h100);
        chk("t4_words", words_loaded, 16);
        chk("t4_trunc", truncated, 0);
        chk("t4_arms", arm_count, 1);
        chk("t4_we_no_hs", we_bad, 0);

        // start during LOAD is ignored
        clear_log();
        pulse_start();
        send(3, 32'h300, 0, 0);
        pulse_start();
        chk("t5b_words_mid", words_loaded, 3);
        send(7, 32'h303, 1, 0);
        wait_idle("t5b");
        check_log("t5b", 10, 32'h300);
        chk("t5b_words", words_loaded, 10);
        chk("t5b_arms", arm_count, 1);

        // reset mid-load, then a clean reload from address 0
        clear_log();
        pulse_start();
        send(3, 32'h400, 0, 0);
        s_tvalid = 1'b1;
        s_tdata  = 32'h403;
        rst = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        chk("t6_tready", s_tready, 0);
        chk("t6_we", bram_we, 0);
        chk("t6_addr", bram_addr, 0);
        chk("t6_data", bram_data_o, 0);
        chk("t6_busy", busy, 0);
        chk("t6_words", words_loaded, 0);
        chk("t6_trunc", truncated, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_arm", arm_count, 0);
        chk("t6_nwrites", log_addr.size(), 3);
        clear_log();
        pulse_start();
        send(4, 32'h500, 1, 0);
        wait_idle("t6r");
        check_log("t6r", 4, 32'h500);
        chk("t6r_words", words_loaded, 4);
        chk("t6r_arms", arm_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
